// File: rtl/playrec_pkg.sv
// rtl/playrec_pkg.sv - constants and state type shared by the playback and recording cores
package playrec_pkg;

  localparam int PR_ADDR_W = 23;
  localparam int PR_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ABORT = 3'd4,
    ST_DONE  = 3'd5
  } play_state_t;

endpackage

// File: rtl/play_core_if.sv
// rtl/play_core_if.sv - control, SDRAM read port and audio stream of the playback core
interface play_core_if #(
  parameter int ADDR_W = playrec_pkg::PR_ADDR_W,
  parameter int DATA_W = playrec_pkg::PR_DATA_W
);
  logic              play_start;
  logic [ADDR_W-1:0] play_start_addr;
  logic [ADDR_W-1:0] play_end_addr;
  logic              play_pause;
  logic              play_stop;
  logic              play_done;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] play_readdata;
  logic              play_sdram_finished;
  logic              play_audio_valid;
  logic [DATA_W-1:0] play_audio_data;
  logic              play_audio_ready;

  modport master (
    output play_start, play_start_addr, play_end_addr, play_pause, play_stop,
    output play_readdata, play_sdram_finished, play_audio_ready,
    input  play_done, play_read, play_addr, play_audio_valid, play_audio_data
  );

  modport slave (
    input  play_start, play_start_addr, play_end_addr, play_pause, play_stop,
    input  play_readdata, play_sdram_finished, play_audio_ready,
    output play_done, play_read, play_addr, play_audio_valid, play_audio_data
  );
endinterface

// File: rtl/play_fifo.sv
// rtl/play_fifo.sv - small synchronous sample FIFO with flush and registered storage
module play_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is reset too so the audio data output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/play_core.sv
// rtl/play_core.sv - playback engine: fetches an inclusive SDRAM word range and streams it to the DAC
module play_core import playrec_pkg::*; #(
  parameter int ADDR_W     = PR_ADDR_W,
  parameter int DATA_W     = PR_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  play_core_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  play_state_t       state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              read_q;
  logic              last_fetched;
  logic              fin;
  logic              push;
  logic              pop;
  logic              flush;
  logic              stop_now;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W-1:0] head;

  assign fin      = read_q && bus.play_sdram_finished;
  assign stop_now = bus.play_stop &&
                    (state == ST_FETCH || state == ST_PAUSE || state == ST_DRAIN);
  assign push     = fin && (state == ST_FETCH);
  assign flush    = (state == ST_IDLE && bus.play_start) || stop_now;
  assign pop      = bus.play_audio_valid && bus.play_audio_ready;

  assign bus.play_audio_valid = (state == ST_FETCH || state == ST_DRAIN) && !fifo_empty;
  assign bus.play_audio_data  = head;
  assign bus.play_read        = read_q;
  assign bus.play_addr        = cur_addr;
  assign bus.play_done        = (state == ST_DONE);

  play_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (bus.play_readdata),
    .pop       (pop),
    .flush     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      end_addr     <= '0;
      read_q       <= 1'b0;
      last_fetched <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.play_start) begin
          if (bus.play_start_addr <= bus.play_end_addr) begin
            cur_addr     <= bus.play_start_addr;
            end_addr     <= bus.play_end_addr;
            last_fetched <= 1'b0;
            read_q       <= 1'b1;
            state        <= ST_FETCH;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_FETCH: begin
          // A read still in flight must be allowed to finish before DONE.
          if (bus.play_stop) begin
            if (read_q && !bus.play_sdram_finished) begin
              state <= ST_ABORT;
            end else begin
              read_q <= 1'b0;
              state  <= ST_DONE;
            end
          end else if (fin) begin
            read_q <= 1'b0;
            if (cur_addr == end_addr) begin
              last_fetched <= 1'b1;
              state        <= bus.play_pause ? ST_PAUSE : ST_DRAIN;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              state    <= bus.play_pause ? ST_PAUSE : ST_FETCH;
            end
          end else if (!read_q) begin
            if (bus.play_pause)  state  <= ST_PAUSE;
            else if (!fifo_full) read_q <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.play_stop)       state <= ST_DONE;
          else if (!bus.play_pause) state <= last_fetched ? ST_DRAIN : ST_FETCH;
        end
        ST_DRAIN: begin
          if (bus.play_stop)           state <= ST_DONE;
          else if (bus.play_pause)     state <= ST_PAUSE;
          else if (fifo_count == '0)   state <= ST_DONE;
        end
        ST_ABORT: if (bus.play_sdram_finished) begin
          read_q <= 1'b0;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_play_core.sv
// tb/tb_play_core.sv - randomized self-checking bench for play_core against a range/memory model
module tb_play_core;
  import playrec_pkg::*;
  localparam int AW = PR_ADDR_W;
  localparam int DW = PR_DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  play_core_if bus ();
  play_core dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int passed = 0;

  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] got[$];
  int reads_done, addr_unstable, data_unstable, done_cnt, done_run, zero_seen;
  int lat = 2;
  bit lat_rand = 0;
  int ready_mode = 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'h5A3C, a[22:7] ^ 16'hC3A5};
  endfunction

  // SDRAM responder and DAC sink, acting 1 time unit after each rising edge.
  initial begin
    int wait_cnt, cur_lat;
    logic [AW-1:0] first_addr;
    logic prev_valid, prev_ready, prev_done, r;
    logic [DW-1:0] prev_data;
    wait_cnt = 0; cur_lat = 1; first_addr = '0;
    prev_valid = 0; prev_ready = 0; prev_done = 0; prev_data = '0;
    bus.play_sdram_finished = 1'b0;
    bus.play_readdata = '0;
    bus.play_audio_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      r = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode != 0);
      bus.play_audio_ready = r;
      if (prev_valid && !prev_ready && bus.play_audio_valid && bus.play_audio_data !== prev_data)
        data_unstable++;
      if (bus.play_audio_valid && r) got.push_back(bus.play_audio_data);
      prev_valid = bus.play_audio_valid; prev_ready = r; prev_data = bus.play_audio_data;
      if (bus.play_done) begin
        done_cnt++;
        if (prev_done) done_run++;
      end
      prev_done = bus.play_done;
      bus.play_sdram_finished = 1'b0;
      bus.play_readdata = DW'($urandom);
      if (bus.play_read && rst_n) begin
        if (bus.play_addr == '0) zero_seen++;
        if (wait_cnt == 0) begin
          first_addr = bus.play_addr;
          cur_lat = lat_rand ? int'($urandom_range(1, 3)) : lat;
        end else if (bus.play_addr !== first_addr) begin
          addr_unstable++;
        end
        if (wait_cnt >= cur_lat) begin
          bus.play_sdram_finished = 1'b1;
          bus.play_readdata = mem_word(bus.play_addr);
          rd_log.push_back(bus.play_addr);
          reads_done++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); got.delete();
    reads_done = 0; addr_unstable = 0; data_unstable = 0;
    done_cnt = 0; done_run = 0; zero_seen = 0;
  endtask

  task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e);
    tick();
    bus.play_start_addr = s;
    bus.play_end_addr = e;
    bus.play_start = 1'b1;
    tick();
    bus.play_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int got_at);
    ok = 0; got_at = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.play_done) begin ok = 1; got_at = got.size(); break; end
      tick();
    end
  endtask

  task automatic wait_read_at(input logic [AW-1:0] a, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.play_read && bus.play_addr == a) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.play_start = 0; bus.play_pause = 0; bus.play_stop = 0;
    bus.play_start_addr = '0; bus.play_end_addr = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    total++; if (bus.play_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", bus.play_done); else passed++;
    total++; if (bus.play_read !== 1'b0) $display("FAIL reset_read: got %0b want 0", bus.play_read); else passed++;
    total++; if (bus.play_addr !== '0) $display("FAIL reset_addr: got %h want 0", bus.play_addr); else passed++;
    total++; if (bus.play_audio_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.play_audio_valid); else passed++;
    total++; if (bus.play_audio_data !== '0) $display("FAIL reset_data: got %h want 0", bus.play_audio_data); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok; int got_at, bad;
    logic [AW-1:0] s;
    s = AW'('h10);
    lat = 2; lat_rand = 0; ready_mode = 1;
    clear_logs();
    start_run(s, AW'('h13));
    total++; if (bus.play_read !== 1'b1) $display("FAIL basic_start_latency: read %0b want 1", bus.play_read); else passed++;
    total++; if (bus.play_addr !== s) $display("FAIL basic_first_addr: got %h want %h", bus.play_addr, s); else passed++;
    wait_done(300, ok, got_at);
    total++; if (!ok) $display("FAIL basic_timeout: done not seen"); else passed++;
    total++; if (got_at != 4) $display("FAIL basic_pops_before_done: got %0d want 4", got_at); else passed++;
    repeat (2) tick();
    total++; if (done_cnt != 1 || done_run != 0) $display("FAIL basic_done_pulse: count %0d run %0d want 1 0", done_cnt, done_run); else passed++;
    bad = (rd_log.size() == 4) ? 0 : 1;
    foreach (rd_log[i]) if (rd_log[i] !== s + AW'(i)) bad++;
    total++; if (bad != 0) $display("FAIL basic_reads: %0d bad of %0d want 4 in order", bad, rd_log.size()); else passed++;
    bad = (got.size() == 4) ? 0 : 1;
    foreach (got[i]) if (got[i] !== mem_word(s + AW'(i))) bad++;
    total++; if (bad != 0) $display("FAIL basic_samples: %0d bad of %0d want 4 in order", bad, got.size()); else passed++;
    total++; if (addr_unstable != 0) $display("FAIL basic_addr_stable: got %0d changes want 0", addr_unstable); else passed++;
  endtask

  task automatic test_top_addr();
    bit ok; int got_at;
    logic [AW-1:0] top;
    top = '1;
    lat = 2; lat_rand = 0; ready_mode = 1;
    clear_logs();
    start_run(top, top);
    wait_done(100, ok, got_at);
    total++; if (!ok) $display("FAIL top_timeout: done not seen"); else passed++;
    repeat (2) tick();
    total++; if (rd_log.size() != 1 || rd_log[0] !== top) $display("FAIL top_reads: %0d reads want 1 at %h", rd_log.size(), top); else passed++;
    total++; if (got.size() != 1 || got[0] !== mem_word(top)) $display("FAIL top_sample: %0d samples want 1 of %h", got.size(), mem_word(top)); else passed++;
    total++; if (bus.play_addr !== top || zero_seen != 0) $display("FAIL top_no_wrap: addr %h zero reads %0d want %h 0", bus.play_addr, zero_seen, top); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok; int got_at, bad;
    logic [AW-1:0] s;
    s = AW'($urandom_range(0, 'h7FFF00));
    lat_rand = 1; ready_mode = 0;
    clear_logs();
    start_run(s, s + AW'(9));
    repeat (60) tick();
    total++; if (reads_done != 4) $display("FAIL bp_reads_when_full: got %0d want 4", reads_done); else passed++;
    total++; if (bus.play_read !== 1'b0 || bus.play_audio_valid !== 1'b1) $display("FAIL bp_idle_full: read %0b valid %0b want 0 1", bus.play_read, bus.play_audio_valid); else passed++;
    total++; if (data_unstable != 0 || got.size() != 0) $display("FAIL bp_hold: unstable %0d popped %0d want 0 0", data_unstable, got.size()); else passed++;
    ready_mode = 1;
    wait_done(400, ok, got_at);
    total++; if (!ok) $display("FAIL bp_timeout: done not seen"); else passed++;
    repeat (2) tick();
    bad = (got.size() == 10 && rd_log.size() == 10) ? 0 : 1;
    foreach (got[i]) if (got[i] !== mem_word(s + AW'(i))) bad++;
    total++; if (bad != 0) $display("FAIL bp_samples: %0d bad, %0d samples %0d reads want 10", bad, got.size(), rd_log.size()); else passed++;
  endtask

  task automatic test_pause();
    bit ok; int got_at, bad, n0, g0, viol;
    logic [AW-1:0] s;
    s = AW'($urandom_range(0, 'h7FFF00));
    lat = 3; lat_rand = 0; ready_mode = 2;
    clear_logs();
    start_run(s, s + AW'(7));
    wait_read_at(s + AW'(2), 200, ok);
    total++; if (!ok) $display("FAIL pause_third_read: not issued"); else passed++;
    bus.play_pause = 1'b1;
    for (int i = 0; i < 20 && bus.play_read; i++) tick();
    tick();
    n0 = reads_done; g0 = got.size(); viol = 0;
    repeat (10) begin
      if (bus.play_read !== 1'b0 || bus.play_audio_valid !== 1'b0) viol++;
      tick();
    end
    total++; if (viol != 0) $display("FAIL pause_quiet: %0d active cycles want 0", viol); else passed++;
    total++; if (n0 != 3 || reads_done != n0 || got.size() != g0) $display("FAIL pause_frozen: reads %0d->%0d pops %0d->%0d want 3 held", n0, reads_done, g0, got.size()); else passed++;
    bus.play_pause = 1'b0;
    wait_done(400, ok, got_at);
    total++; if (!ok) $display("FAIL pause_timeout: done not seen"); else passed++;
    repeat (2) tick();
    bad = (got.size() == 8) ? 0 : 1;
    foreach (got[i]) if (got[i] !== mem_word(s + AW'(i))) bad++;
    total++; if (bad != 0) $display("FAIL pause_samples: %0d bad of %0d want 8 in order", bad, got.size()); else passed++;
  endtask

  task automatic test_stop();
    bit ok; int got_at, viol;
    logic [AW-1:0] s;
    s = AW'($urandom_range(0, 'h7FFF00));
    lat = 5; lat_rand = 0; ready_mode = 1;
    clear_logs();
    start_run(s, s + AW'(19));
    wait_read_at(s + AW'(1), 100, ok);
    total++; if (!ok) $display("FAIL stop_second_read: not issued"); else passed++;
    bus.play_stop = 1'b1;
    tick();
    bus.play_stop = 1'b0;
    total++; if (bus.play_read !== 1'b1 || bus.play_audio_valid !== 1'b0) $display("FAIL stop_abort: read %0b valid %0b want 1 0", bus.play_read, bus.play_audio_valid); else passed++;
    viol = 0; ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.play_done) begin ok = 1; break; end
      if (bus.play_read !== 1'b1 || bus.play_audio_valid !== 1'b0) viol++;
      tick();
    end
    total++; if (!ok || viol != 0) $display("FAIL stop_hold: done %0b violations %0d want 1 0", ok, viol); else passed++;
    total++; if (bus.play_read !== 1'b0) $display("FAIL stop_read_drop: got %0b want 0", bus.play_read); else passed++;
    repeat (2) tick();
    total++; if (done_cnt != 1 || bus.play_audio_valid !== 1'b0) $display("FAIL stop_done_once: count %0d valid %0b want 1 0", done_cnt, bus.play_audio_valid); else passed++;
    clear_logs();
    start_run(AW'('h40), AW'('h40));
    total++; if (bus.play_read !== 1'b1) $display("FAIL stop_back_to_idle: read %0b want 1", bus.play_read); else passed++;
    wait_done(100, ok, got_at);
    repeat (2) tick();
    total++; if (got.size() != 1 || got[0] !== mem_word(AW'('h40))) $display("FAIL stop_restart_sample: %0d samples want 1", got.size()); else passed++;
  endtask

  task automatic test_empty_range();
    clear_logs();
    start_run(AW'('h20), AW'('h1F));
    total++; if (bus.play_done !== 1'b1 || bus.play_read !== 1'b0) $display("FAIL empty_done: done %0b read %0b want 1 0", bus.play_done, bus.play_read); else passed++;
    tick();
    total++; if (bus.play_done !== 1'b0) $display("FAIL empty_pulse_width: done %0b want 0", bus.play_done); else passed++;
    repeat (3) tick();
    total++; if (reads_done != 0 || done_cnt != 1) $display("FAIL empty_no_read: reads %0d dones %0d want 0 1", reads_done, done_cnt); else passed++;
  endtask

  task automatic test_reset_midfetch();
    bit ok; int got_at;
    lat = 4; lat_rand = 0; ready_mode = 1;
    clear_logs();
    start_run(AW'('h300), AW'('h305));
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.play_done, bus.play_read, bus.play_audio_valid} !== 3'b000 || bus.play_addr !== '0 || bus.play_audio_data !== '0)
      $display("FAIL midreset_outputs: done %0b read %0b valid %0b addr %h data %h want all 0", bus.play_done, bus.play_read, bus.play_audio_valid, bus.play_addr, bus.play_audio_data);
    else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.play_read !== 1'b0 || bus.play_audio_valid !== 1'b0) $display("FAIL midreset_idle: read %0b valid %0b want 0 0", bus.play_read, bus.play_audio_valid); else passed++;
    clear_logs();
    start_run(AW'('h30), AW'('h31));
    total++; if (bus.play_read !== 1'b1) $display("FAIL midreset_restart: read %0b want 1", bus.play_read); else passed++;
    wait_done(100, ok, got_at);
    repeat (2) tick();
    total++; if (got.size() != 2 || got[0] !== mem_word(AW'('h30)) || got[1] !== mem_word(AW'('h31))) $display("FAIL midreset_samples: %0d samples want 2", got.size()); else passed++;
  endtask

  task automatic test_random();
    bit ok; int got_at, bad, len;
    logic [AW-1:0] s;
    for (int it = 0; it < 4; it++) begin
      len = int'($urandom_range(1, 9));
      s = AW'($urandom_range(0, 'h7FFF00));
      lat_rand = 1; ready_mode = 2;
      clear_logs();
      start_run(s, s + AW'(len - 1));
      wait_done(400, ok, got_at);
      repeat (2) tick();
      bad = (ok && got.size() == len && rd_log.size() == len) ? 0 : 1;
      foreach (got[i]) if (got[i] !== mem_word(s + AW'(i))) bad++;
      total++; if (bad != 0) $display("FAIL random_run%0d: %0d bad, %0d samples %0d reads want %0d", it, bad, got.size(), rd_log.size(), len); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_addr();
    test_backpressure();
    test_pause();
    test_stop();
    test_empty_range();
    test_reset_midfetch();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/play_core.md
Name: play_core

Overview:
- Playback engine, the read-side counterpart of the recording core.
- Fetches 32-bit stereo samples from SDRAM over an inclusive address range and buffers them in a small FIFO.
- Streams buffered samples to the audio DAC interface with a valid/ready handshake.
- Sits between the top-level controller, the SDRAM arbiter port and the audio output path.

Parameters:
ADDR_W, 23, SDRAM word-address width
DATA_W, 32, sample width (L/R packed)
FIFO_DEPTH, 4, sample buffer entries; power of two, ≥2

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset
play_start  in  1  level; begins playback when sampled high in IDLE
play_start_addr  in  ADDR_W  first word address, latched at start
play_end_addr  in  ADDR_W  last word address (inclusive), latched at start
play_pause  in  1  level; freezes fetch and output while high
play_stop  in  1  level; aborts playback
play_done  out  1  one-cycle pulse at end or abort
play_read  out  1  SDRAM read request
play_addr  out  ADDR_W  SDRAM read address
play_readdata  in  DATA_W  SDRAM read data, valid with finished
play_sdram_finished  in  1  SDRAM access-complete strobe
play_audio_valid  out  1  sample available to DAC
play_audio_data  out  DATA_W  sample to DAC
play_audio_ready  in  1  DAC accepts sample

Interface: one clock; reset is asynchronous and active-low. i_clk is the clock and i_rst_n the reset.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, FIFO emptied, address counter=0. All outputs 0: play_done, play_read, play_addr, play_audio_valid, play_audio_data.
- States: IDLE, FETCH, PAUSE, DRAIN, ABORT, DONE.
- IDLE:
  - play_start=1 and start_addr≤end_addr: latch both addresses, clear FIFO, go FETCH.
  - play_start=1 and start_addr>end_addr: go DONE; no SDRAM read is issued.
- FETCH:
  - If FIFO count<FIFO_DEPTH, assert play_read with play_addr=current address.
  - play_read and play_addr are held stable until play_sdram_finished.
  - At most one read is outstanding.
  - On finished: push play_readdata into the FIFO and deassert play_read the next cycle. Then one of:
    - address==end_addr: set last_fetched, go DRAIN.
    - otherwise: address+1.
  - FIFO full: play_read=0, no new request.
- Audio side:
  - play_audio_valid = FIFO non-empty and state∈{FETCH, DRAIN}.
  - play_audio_data = FIFO head, registered.
  - Pop on valid&&ready.
  - Push and pop in the same cycle leave count unchanged.
  - Data is stable while valid is high and ready is low.
- Latency:
  - start sampled at cycle 0 → play_read=1 at cycle 1.
  - finished at cycle k → play_audio_valid=1 at cycle k+1 if the FIFO was empty.
- PAUSE:
  - Entered from FETCH/DRAIN while play_pause=1.
  - If a read is outstanding, it completes and its data is pushed first; the state transition happens on that finished cycle.
  - In PAUSE: play_read=0, play_audio_valid=0, FIFO contents retained.
  - play_pause=0 returns to DRAIN if last_fetched, else FETCH.
- DRAIN: no reads. FIFO empty → DONE.
- Stop:
  - play_stop=1 in FETCH/PAUSE/DRAIN triggers it.
  - Read outstanding: go ABORT. ABORT holds play_read until finished, discards the data, then goes DONE.
  - No read outstanding: go DONE directly.
  - FIFO flushed; play_audio_valid=0 from the cycle after stop is sampled.
- DONE: play_done=1 for exactly one cycle, then IDLE.
- Priority: stop > pause > normal progress. play_start is ignored outside IDLE.
- Address arithmetic: ADDR_W-bit unsigned. End detection is by equality, so end_addr=2^ADDR_W−1 terminates with no wrap.
- Single-word range (start==end): one read, one sample, DONE.

Decomposition:
- Shared package (playrec_pkg):
  - state enum play_state_t.
  - ADDR_W/DATA_W constants, shared with the recording core.
- Sub-module play_fifo (synchronous FIFO):
  - Parameterised DEPTH/WIDTH.
  - Ports: push, pop, flush, full, empty, count, head; same clock/reset.
  - Instantiated once.

Test Plan:
1. start_addr=0x10, end_addr=0x13, finished 2 cycles after each read, ready=1 → reads at 0x10..0x13 in order; 4 samples out equal to memory model; play_done pulses once after the 4th pop.
2. start=end=0x7FFFFF → exactly one read at 0x7FFFFF, one sample, done; play_addr never wraps to 0.
3. ready=0 throughout, range of 10 words → exactly 4 reads complete, play_read low afterward; raise ready → remaining 6 fetched, 10 samples delivered in order.
4. Pause asserted in the same cycle as an outstanding read → that read completes and its data is buffered; no further reads and valid=0 while paused; release → sequence resumes with no lost or duplicate samples.
5. Stop mid-read with finished delayed 5 cycles → play_read stays high until finished, then play_done pulse, FIFO empty, valid=0, IDLE.
6. start_addr=0x20, end_addr=0x1F → no read, play_done pulse next cycle. Then assert i_rst_n=0 mid-FETCH → all outputs 0 immediately; after release, state is IDLE.
